vec_mem_requester: RTL and testbench

Processor-side initiator for the word-wide data-memory port. Accepts one scalar or vector (V-bit, LANES words) load/store request from the execute stage and serialises it into consecutive single-word memory accesses. For loads it reassembles the returned words into one V-bit result. It flags stores that target the read-only region and stalls the pipeline while busy.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/vec_mem_requester.sv | 118 +++++++++++
 tb/tb_vec_mem_requester.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-map constants, FSM state type and lane helper for the
// data-memory requester.
package mem_pkg;

  localparam int S     = 32;
  localparam int V     = 192;
  localparam int LANES = V / S;

  // Data-memory map as seen by the controller: read-only constants, then RAM.
  localparam int ROM_START = 500;
  localparam int ROM_END   = 30499;
  localparam int RAM_START = 30500;
  localparam int RAM_END   = 65535;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word i of a V-bit vector (lane 0 in the low bits).
  function automatic logic [S-1:0] lane_slice(input logic [V-1:0] v, input int unsigned i);
    return v[i*S +: S];
  endfunction

endpackage

// File: rtl/vec_mem_requester.sv
// Serialises one scalar/vector load or store into consecutive single-word
// memory accesses, reassembles load data, and flags stores into the ROM region.
module vec_mem_requester #(
  parameter int S         = mem_pkg::S,
  parameter int V         = mem_pkg::V,
  parameter int ROM_START = mem_pkg::ROM_START,
  parameter int ROM_END   = mem_pkg::ROM_END
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic         req_vec,
  input  logic [S-1:0] req_addr,
  input  logic [V-1:0] req_wd,
  output logic [S-1:0] mem_addr,
  output logic         mem_we,
  output logic [S-1:0] mem_wd,
  input  logic [S-1:0] mem_rd,
  output logic         resp_valid,
  output logic [V-1:0] resp_rd,
  output logic         resp_err,
  output logic         busy
);
  import mem_pkg::state_t;
  import mem_pkg::IDLE;
  import mem_pkg::XFER;
  import mem_pkg::RESP;

  localparam int NL = V / S;
  localparam int IW = (NL > 1) ? $clog2(NL) : 1;

  state_t         state, state_nxt;
  logic           we_q, vec_q, err_q;
  logic [S-1:0]   base_q;
  logic [V-1:0]   wd_q, rd_acc;
  logic [IW-1:0]  idx, last_idx;
  logic [S-1:0]   xfer_addr;
  logic           xfer_rom, last, accept;

  // Address wraps modulo 2^S; ROM membership is judged on the wrapped address.
  assign xfer_addr = base_q + S'(idx);
  assign xfer_rom  = (xfer_addr >= S'(ROM_START)) && (xfer_addr <= S'(ROM_END));
  assign last_idx  = vec_q ? IW'(NL - 1) : '0;
  assign last      = (idx == last_idx);
  assign accept    = (state == IDLE) && req_valid;
  assign resp_rd   = rd_acc;

  // State register; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = XFER;
      XFER:    if (last)      state_nxt = RESP;
      RESP:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so the memory bus is glitch-free.
  always_comb begin
    req_ready  = (state == IDLE) && !reset;
    busy       = (state != IDLE);
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state)
      XFER: begin
        mem_addr = xfer_addr;
        mem_we   = we_q && !xfer_rom;
        for (int i = 0; i < NL; i++)
          if (idx == IW'(i)) mem_wd = wd_q[i*S +: S];
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

  // Request capture, lane counter, error flag and load-data assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q   <= 1'b0;
      vec_q  <= 1'b0;
      err_q  <= 1'b0;
      base_q <= '0;
      wd_q   <= '0;
      rd_acc <= '0;
      idx    <= '0;
    end else if (accept) begin
      we_q   <= req_we;
      vec_q  <= req_vec;
      base_q <= req_addr;
      wd_q   <= req_wd;
      err_q  <= 1'b0;
      rd_acc <= '0;
      idx    <= '0;
    end else if (state == XFER) begin
      if (we_q && xfer_rom) err_q <= 1'b1;
      if (!we_q)
        for (int i = 0; i < NL; i++)
          if (idx == IW'(i)) rd_acc[i*S +: S] <= mem_rd;
      if (!last) idx <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_vec_mem_requester.sv
// Directed scoreboard bench for vec_mem_requester: stimulus pushes expected
// memory accesses and responses; a negedge monitor pops and compares them.
module tb_vec_mem_requester;
  import mem_pkg::*;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wd; } mem_exp_t;
  typedef struct { logic [191:0] rd; logic err; } resp_exp_t;

  logic         clk = 0, reset = 1;
  logic         req_valid = 0, req_we = 0, req_vec = 0;
  logic [31:0]  req_addr = 0;
  logic [191:0] req_wd = 0;
  logic         req_ready, mem_we, resp_valid, resp_err, busy;
  logic [31:0]  mem_addr, mem_wd, mem_rd;
  logic [191:0] resp_rd;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  int n_cmp = 0, n_bad = 0;

  vec_mem_requester dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_vec(req_vec), .req_addr(req_addr), .req_wd(req_wd),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_err(resp_err), .busy(busy)
  );

  // Memory model: every word reads as its address plus 0x100.
  assign mem_rd = mem_addr + 32'h100;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: XFER cycles are busy without resp_valid; RESP has resp_valid.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy && !resp_valid) begin
        if (mem_q.size() == 0) flag("unexpected memory access");
        else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          check("mem_addr", 192'(mem_addr), 192'(e.addr));
          check("mem_we",   192'(mem_we),   192'(e.we));
          check("mem_wd",   192'(mem_wd),   192'(e.wd));
        end
      end else if (!busy) begin
        check("idle_mem_bus", 192'({mem_addr, mem_we, mem_wd}), 192'(0));
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) flag("unexpected resp_valid");
        else begin
          resp_exp_t r;
          r = resp_q.pop_front();
          check("resp_rd",  resp_rd, r.rd);
          check("resp_err", 192'(resp_err), 192'(r.err));
        end
      end
    end
  end

  task automatic push_load(input logic [31:0] addr, input logic vec, input logic [191:0] rd);
    for (int i = 0; i < (vec ? 6 : 1); i++) mem_q.push_back('{addr + i, 1'b0, 32'h0});
    resp_q.push_back('{rd, 1'b0});
  endtask

  task automatic push_store(input logic [31:0] addr, input logic vec, input logic [191:0] wd,
                            input logic [5:0] we_mask, input logic err, input int nlanes);
    for (int i = 0; i < nlanes; i++)
      mem_q.push_back('{addr + i, we_mask[i], lane_slice(wd, i)});
    if (nlanes == (vec ? 6 : 1)) resp_q.push_back('{192'h0, err});
  endtask

  // Called #1 after a posedge; returns #1 after the accept edge.
  task automatic send(input logic we, input logic vec, input logic [31:0] addr, input logic [191:0] wd);
    req_we = we; req_vec = vec; req_addr = addr; req_wd = wd; req_valid = 1;
    for (int k = 0; k < 50 && !req_ready; k++) begin @(posedge clk); #1; end
    if (!req_ready) flag("req_ready timeout");
    @(posedge clk); #1;
    req_valid = 0; req_we = 0; req_vec = 0; req_addr = 0; req_wd = 0;
  endtask

  task automatic wait_resp(input int n, input logic [191:0] rd);
    int k;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!resp_valid && k < 20);
    check("resp_latency", 192'(k), 192'(n));
    @(posedge clk); #1;
    check("resp_rd_held", resp_rd, rd);
    check("idle_after_resp", 192'({busy, req_ready, resp_valid}), 192'(3'b010));
  endtask

  initial begin
    logic [191:0] wd_st;
    #2;
    check("reset_outputs", 192'({req_ready, busy, mem_we, resp_valid, resp_err, mem_addr}), 192'(0));
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1 check("ready_after_reset", 192'(req_ready), 192'(1));
    @(posedge clk); #1;

    // Scalar store to RAM.
    push_store(32'd30600, 1'b0, 192'hDEADBEEF, 6'b000001, 1'b0, 1);
    send(1'b1, 1'b0, 32'd30600, 192'hDEADBEEF);
    wait_resp(1, 192'h0);

    // Vector load: words 0x358..0x35D.
    push_load(32'd600, 1'b1, {32'h35D, 32'h35C, 32'h35B, 32'h35A, 32'h359, 32'h358});
    send(1'b0, 1'b1, 32'd600, 192'h0);
    wait_resp(6, {32'h35D, 32'h35C, 32'h35B, 32'h35A, 32'h359, 32'h358});

    // Vector store straddling ROM_END: first three lanes suppressed.
    wd_st = {32'h66666666, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    push_store(32'd30497, 1'b1, wd_st, 6'b111000, 1'b1, 6);
    send(1'b1, 1'b1, 32'd30497, wd_st);
    wait_resp(6, 192'h0);

    // Address wrap on a vector load.
    push_load(32'hFFFFFFFE, 1'b1, {32'h103, 32'h102, 32'h101, 32'h100, 32'hFF, 32'hFE});
    send(1'b0, 1'b1, 32'hFFFFFFFE, 192'h0);
    wait_resp(6, {32'h103, 32'h102, 32'h101, 32'h100, 32'hFF, 32'hFE});

    // Scalar load from ROM is legal; upper lanes zero.
    push_load(32'd1000, 1'b0, 192'h4E8);
    send(1'b0, 1'b0, 32'd1000, 192'h0);
    wait_resp(1, 192'h4E8);

    // Busy rejection: req_valid held with a new address during the vector op.
    push_load(32'd700, 1'b1, {32'h3C1, 32'h3C0, 32'h3BF, 32'h3BE, 32'h3BD, 32'h3BC});
    push_load(32'd800, 1'b1, {32'h425, 32'h424, 32'h423, 32'h422, 32'h421, 32'h420});
    req_we = 0; req_vec = 1; req_addr = 32'd700; req_valid = 1;
    check("ready_before_busy", 192'(req_ready), 192'(1));
    @(posedge clk); #1;
    req_addr = 32'd800;
    for (int k = 0; k < 7; k++) begin
      check("busy_reject", 192'({req_ready, busy}), 192'(2'b01));
      @(posedge clk); #1;
    end
    check("ready_after_busy", 192'(req_ready), 192'(1));
    @(posedge clk); #1;
    req_valid = 0; req_vec = 0; req_addr = 0;
    wait_resp(6, {32'h425, 32'h424, 32'h423, 32'h422, 32'h421, 32'h420});

    // Reset during lane 3 of a vector store.
    push_store(32'd30600, 1'b1, wd_st, 6'b111111, 1'b0, 3);
    send(1'b1, 1'b1, 32'd30600, wd_st);
    repeat (3) @(posedge clk);
    #1 check("lane3_write", 192'({mem_we, mem_addr}), 192'({1'b1, 32'd30603}));
    reset = 1;
    #1 check("abort_outputs", 192'({mem_we, busy, resp_valid, req_ready}), 192'(0));
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1 check("ready_after_abort", 192'({req_ready, busy}), 192'(2'b10));
    repeat (10) @(posedge clk);
    #1;
    check("mem_q_drained", 192'(mem_q.size()), 192'(0));
    check("resp_q_drained", 192'(resp_q.size()), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
